if_id_stage: RTL and testbench

IF_ID_STAGE -- requirements
Module: if_id_stage

---
 rtl/mips_pkg.sv | 49 ++++
 rtl/if_id_skid_buf.sv | 109 ++++++++++
 rtl/if_id_stage.sv | 102 ++++++++++
 tb/tb_if_id_stage.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants, decoded-instruction type and field decoder
// for the fetch/decode boundary.
package mips_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned IMM_W    = 16;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 6'h05;

    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned RS_LSB     = 21;
    localparam int unsigned RT_LSB     = 16;
    localparam int unsigned RD_LSB     = 11;
    localparam int unsigned SHAMT_LSB  = 6;
    localparam int unsigned FUNCT_LSB  = 0;
    localparam int unsigned IMM_LSB    = 0;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [REG_W-1:0]    r_reg1;
        logic [REG_W-1:0]    r_reg2;
        logic [REG_W-1:0]    w_reg;
        logic [REG_W-1:0]    shift;
        logic [FUNCT_W-1:0]  funct;
        logic [IMM_W-1:0]    inst_16bit;
        logic                is_branch;
    } decoded_t;

    // R-type writes rd, every other format writes rt
    function automatic decoded_t decode(input logic [INSTR_W-1:0] instr);
        decoded_t d;
        d.opcode     = instr[OPCODE_LSB +: OPCODE_W];
        d.r_reg1     = instr[RS_LSB +: REG_W];
        d.r_reg2     = instr[RT_LSB +: REG_W];
        d.w_reg      = (d.opcode == OP_RTYPE) ? instr[RD_LSB +: REG_W]
                                              : instr[RT_LSB +: REG_W];
        d.shift      = instr[SHAMT_LSB +: REG_W];
        d.funct      = instr[FUNCT_LSB +: FUNCT_W];
        d.inst_16bit = instr[IMM_LSB +: IMM_W];
        d.is_branch  = (d.opcode == OP_BEQ) || (d.opcode == OP_BNE);
        return d;
    endfunction

endpackage

// File: rtl/if_id_skid_buf.sv
// Valid/ready holding buffer between fetch and decode.
// IF_ID_SKID_EN selects a two-entry (main + skid) buffer with registered in_ready.
module if_id_skid_buf #(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_v_q, main_v_n;
    logic [W-1:0] main_d_q, main_d_n;
    logic         in_fire, out_fire;

    assign out_valid = main_v_q;
    assign out_data  = main_d_q;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = main_v_q && out_ready;

`ifdef IF_ID_SKID_EN
    logic         skid_v_q, skid_v_n;
    logic [W-1:0] skid_d_q, skid_d_n;
    logic         ready_q;

    // ready_q mirrors "fewer than two entries held"; flush still blocks intake
    assign in_ready = ready_q && !flush;

    always_comb begin
        main_v_n = main_v_q;
        main_d_n = main_d_q;
        skid_v_n = skid_v_q;
        skid_d_n = skid_d_q;
        if (flush) begin
            main_v_n = 1'b0;
            skid_v_n = 1'b0;
        end else if (out_fire || !main_v_q) begin
            if (skid_v_q) begin
                main_v_n = 1'b1;
                main_d_n = skid_d_q;
                skid_v_n = in_fire;
                if (in_fire) begin
                    skid_d_n = in_data;
                end
            end else begin
                main_v_n = in_fire;
                if (in_fire) begin
                    main_d_n = in_data;
                end
            end
        end else if (in_fire) begin
            skid_v_n = 1'b1;
            skid_d_n = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v_q <= 1'b0;
            main_d_q <= '0;
            skid_v_q <= 1'b0;
            skid_d_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            main_v_q <= main_v_n;
            main_d_q <= main_d_n;
            skid_v_q <= skid_v_n;
            skid_d_q <= skid_d_n;
            ready_q  <= !(main_v_n && skid_v_n);
        end
    end
`else
    logic live_q;

    // Single entry: refill in the same cycle the held word leaves
    assign in_ready = live_q && !flush && (!main_v_q || out_ready);

    always_comb begin
        main_v_n = main_v_q;
        main_d_n = main_d_q;
        if (flush) begin
            main_v_n = 1'b0;
        end else if (in_fire) begin
            main_v_n = 1'b1;
            main_d_n = in_data;
        end else if (out_fire) begin
            main_v_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v_q <= 1'b0;
            main_d_q <= '0;
            live_q   <= 1'b0;
        end else begin
            main_v_q <= main_v_n;
            main_d_q <= main_d_n;
            live_q   <= 1'b1;
        end
    end
`endif

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register: buffers fetched PC/instruction pairs, decodes the
// held word and computes the branch target. Optional skid buffer: IF_ID_SKID_EN.
module if_id_stage
    import mips_pkg::*;
#(
    parameter int unsigned PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PC_W-1:0] in_pc,
    input  logic [PC_W-1:0] in_instr,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [PC_W-1:0] out_pc_plus4,
    output logic [5:0]      opcode,
    output logic [4:0]      r_reg1,
    output logic [4:0]      r_reg2,
    output logic [4:0]      w_reg,
    output logic [4:0]      shift,
    output logic [5:0]      funct,
    output logic [15:0]     inst_16bit,
    output logic [PC_W-1:0] imm_sext,
    output logic            is_branch,
    output logic [PC_W-1:0] branch_target,
    output logic [7:0]      bubble_cnt
);

    localparam int unsigned BUF_W = 2 * PC_W;

    logic [BUF_W-1:0] buf_in, buf_out;
    logic [PC_W-1:0]  held_pc, held_instr, held_pc4, held_imm;
    decoded_t         dec;

    assign buf_in = {in_pc, in_instr};

    if_id_skid_buf #(
        .W (BUF_W)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (buf_in),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (buf_out)
    );

    assign held_pc    = buf_out[BUF_W-1:PC_W];
    assign held_instr = buf_out[PC_W-1:0];

    always_comb begin
        dec      = decode(held_instr[INSTR_W-1:0]);
        held_pc4 = held_pc + PC_W'(4);
        held_imm = {{(PC_W-IMM_W){dec.inst_16bit[IMM_W-1]}}, dec.inst_16bit};
    end

    // Everything downstream sees is forced to zero while nothing is held
    always_comb begin
        out_pc        = '0;
        out_pc_plus4  = '0;
        opcode        = '0;
        r_reg1        = '0;
        r_reg2        = '0;
        w_reg         = '0;
        shift         = '0;
        funct         = '0;
        inst_16bit    = '0;
        imm_sext      = '0;
        is_branch     = 1'b0;
        branch_target = '0;
        if (out_valid) begin
            out_pc        = held_pc;
            out_pc_plus4  = held_pc4;
            opcode        = dec.opcode;
            r_reg1        = dec.r_reg1;
            r_reg2        = dec.r_reg2;
            w_reg         = dec.w_reg;
            shift         = dec.shift;
            funct         = dec.funct;
            inst_16bit    = dec.inst_16bit;
            imm_sext      = held_imm;
            is_branch     = dec.is_branch;
            branch_target = held_pc4 + (held_imm << 2);
        end
    end

    // Saturating count of empty output cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= 8'd0;
        end else if (!out_valid && (bubble_cnt != 8'hFF)) begin
            bubble_cnt <= bubble_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: hand-decoded vector table plus a
// scoreboard queue for stall, flush, throughput, random and reset sequences.
module tb_if_id_stage;

`ifdef IF_ID_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic        clk, rst_n, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_pc, in_instr, out_pc, out_pc_plus4, imm_sext, branch_target;
    logic [5:0]  opcode, funct;
    logic [4:0]  r_reg1, r_reg2, w_reg, shift;
    logic [15:0] inst_16bit;
    logic        is_branch;
    logic [7:0]  bubble_cnt;

    if_id_stage #(.PC_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_pc_plus4(out_pc_plus4),
        .opcode(opcode), .r_reg1(r_reg1), .r_reg2(r_reg2), .w_reg(w_reg),
        .shift(shift), .funct(funct), .inst_16bit(inst_16bit), .imm_sext(imm_sext),
        .is_branch(is_branch), .branch_target(branch_target), .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, instr;
        logic [5:0]  op;
        logic [4:0]  r1, r2, wreg, sh;
        logic [5:0]  fn;
        logic [31:0] imm;
        logic        br;
        logic [31:0] pc4, tgt;
    } vec_t;

    vec_t        q[$];
    vec_t        idle;
    int          errors = 0;
    int          checks = 0;
    int          exp_bub;
    logic        prev_hold;
    logic [31:0] prev_pc, prev_imm;
    logic [4:0]  prev_wreg;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [31:0] pc, input logic [31:0] instr,
                                 input logic [5:0] op, input logic [4:0] r1, input logic [4:0] r2,
                                 input logic [4:0] wreg, input logic [4:0] sh, input logic [5:0] fn,
                                 input logic [31:0] imm, input logic br,
                                 input logic [31:0] pc4, input logic [31:0] tgt);
        vec_t v;
        v.pc = pc; v.instr = instr; v.op = op; v.r1 = r1; v.r2 = r2; v.wreg = wreg;
        v.sh = sh; v.fn = fn; v.imm = imm; v.br = br; v.pc4 = pc4; v.tgt = tgt;
        return v;
    endfunction

    // Reference decode used for streamed words
    function automatic vec_t model(input logic [31:0] pc, input logic [31:0] instr);
        vec_t v;
        logic [15:0] im;
        im     = instr[15:0];
        v.pc   = pc;
        v.instr = instr;
        v.op   = instr[31:26];
        v.r1   = instr[25:21];
        v.r2   = instr[20:16];
        v.wreg = (instr[31:26] == 6'd0) ? instr[15:11] : instr[20:16];
        v.sh   = instr[10:6];
        v.fn   = instr[5:0];
        v.imm  = {{16{im[15]}}, im};
        v.br   = (v.op == 6'h04) || (v.op == 6'h05);
        v.pc4  = pc + 32'd4;
        v.tgt  = v.pc4 + (v.imm << 2);
        return v;
    endfunction

    task automatic compare(input vec_t e);
        logic [15:0] im;
        im = e.instr[15:0];
        chk("out_pc", out_pc, e.pc);
        chk("out_pc_plus4", out_pc_plus4, e.pc4);
        chk("opcode", 32'(opcode), 32'(e.op));
        chk("r_reg1", 32'(r_reg1), 32'(e.r1));
        chk("r_reg2", 32'(r_reg2), 32'(e.r2));
        chk("w_reg", 32'(w_reg), 32'(e.wreg));
        chk("shift", 32'(shift), 32'(e.sh));
        chk("funct", 32'(funct), 32'(e.fn));
        chk("inst_16bit", 32'(inst_16bit), 32'(im));
        chk("imm_sext", imm_sext, e.imm);
        chk("is_branch", 32'(is_branch), 32'(e.br));
        chk("branch_target", branch_target, e.tgt);
    endtask

    // One clock: drive at negedge, sample mid-cycle, score, then wait the posedge
    task automatic step(input logic iv, input vec_t v, input logic ordy, input logic fl,
                        output logic acc, output logic rdy);
        logic ofire;
        vec_t e;
        @(negedge clk);
        in_valid = iv; in_pc = v.pc; in_instr = v.instr; out_ready = ordy; flush = fl;
        #2;
        rdy = in_ready;
        chk("bubble_cnt", 32'(bubble_cnt), 32'(exp_bub));
        if (prev_hold) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_pc", out_pc, prev_pc);
            chk("hold_imm", imm_sext, prev_imm);
            chk("hold_wreg", 32'(w_reg), 32'(prev_wreg));
        end
        if (fl) chk("in_ready_during_flush", 32'(in_ready), 32'd0);
        if (!out_valid)
            chk("idle_outputs_zero", out_pc | out_pc_plus4 | imm_sext | branch_target |
                32'(opcode) | 32'(r_reg1) | 32'(r_reg2) | 32'(w_reg) | 32'(shift) |
                32'(funct) | 32'(inst_16bit) | 32'(is_branch), 32'd0);
        ofire = out_valid && ordy && !fl;
        if (ofire) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got pc=%h expected no output", out_pc);
            end else begin
                e = q.pop_front();
                compare(e);
            end
        end
        prev_hold = out_valid && !ofire && !fl;
        prev_pc   = out_pc;
        prev_imm  = imm_sext;
        prev_wreg = w_reg;
        acc = iv && in_ready;
        if (acc) q.push_back(v);
        if (fl) q.delete();
        if (!out_valid && exp_bub < 255) exp_bub++;
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = '0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_bubble_cnt", 32'(bubble_cnt), 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        q.delete();
        prev_hold = 1'b0;
        exp_bub = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        exp_bub = 1;
        #1;
        chk("in_ready_after_release", 32'(in_ready), 32'd1);
    endtask

    vec_t tv[6];
    vec_t w[4];
    logic a, r;
    logic ir[4];
    int   idx, nacc;

    initial begin
        idle = '{default: '0};
        rst_n = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = '0; exp_bub = 0; prev_hold = 1'b0;

        tv[0] = mkv(32'h0000_0000, 32'h012A4020, 6'h00, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20,
                    32'h0000_4020, 1'b0, 32'h0000_0004, 32'h0001_0084);
        tv[1] = mkv(32'h0000_0100, 32'h1109FFFF, 6'h04, 5'd8, 5'd9, 5'd9, 5'd31, 6'h3F,
                    32'hFFFF_FFFF, 1'b1, 32'h0000_0104, 32'h0000_0100);
        tv[2] = mkv(32'hFFFF_FFFC, 32'h14A60003, 6'h05, 5'd5, 5'd6, 5'd6, 5'd0, 6'h03,
                    32'h0000_0003, 1'b1, 32'h0000_0000, 32'h0000_000C);
        tv[3] = mkv(32'h0000_2000, 32'h8C880010, 6'h23, 5'd4, 5'd8, 5'd8, 5'd0, 6'h10,
                    32'h0000_0010, 1'b0, 32'h0000_2004, 32'h0000_2044);
        tv[4] = mkv(32'h0000_3000, 32'h2108FFF8, 6'h08, 5'd8, 5'd8, 5'd8, 5'd31, 6'h38,
                    32'hFFFF_FFF8, 1'b0, 32'h0000_3004, 32'h0000_2FE4);
        tv[5] = mkv(32'h0000_0040, 32'h00084880, 6'h00, 5'd0, 5'd8, 5'd9, 5'd2, 6'h00,
                    32'h0000_4880, 1'b0, 32'h0000_0044, 32'h0001_2244);

        do_reset();

        // Hand-decoded vectors, one at a time through an empty stage
        for (int i = 0; i < 6; i++) begin
            step(1'b1, tv[i], 1'b1, 1'b0, a, r);
            chk("tv_accept", 32'(a), 32'd1);
            #1;
            chk("tv_latency_valid", 32'(out_valid), 32'd1);
            step(1'b0, idle, 1'b1, 1'b0, a, r);
        end

        // Four words with the consumer stalled for three cycles
        for (int i = 0; i < 4; i++) w[i] = model(32'h0000_1000 + 32'(i * 4), $urandom());
        idx = 0;
        for (int c = 0; c < 60 && !(idx == 4 && q.size() == 0); c++) begin
            if (idx < 4) step(1'b1, w[idx], c >= 3, 1'b0, a, r);
            else         step(1'b0, idle, 1'b1, 1'b0, a, r);
            if (c < 4) ir[c] = r;
            if (a) idx++;
        end
        chk("stall_all_accepted", 32'(idx), 32'd4);
        chk("stall_all_emitted", 32'(q.size()), 32'd0);
        chk("stall_ready_before_full", 32'(ir[CAP-1]), 32'd1);
        chk("stall_ready_when_full", 32'(ir[CAP]), 32'd0);

        // Flush with held entries and a word offered in the flush cycle
        step(1'b1, model(32'h0000_5000, 32'h012A4020), 1'b0, 1'b0, a, r);
        step(1'b1, model(32'h0000_5004, 32'h1109FFFF), 1'b0, 1'b0, a, r);
        step(1'b1, model(32'h0000_5008, 32'h8C880010), 1'b1, 1'b1, a, r);
        chk("flush_input_rejected", 32'(a), 32'd0);
        #1;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, idle, 1'b1, 1'b0, a, r);

        // Back-to-back stream with the consumer always ready
        nacc = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, model(32'h0000_6000 + 32'(nacc * 4), $urandom()), 1'b1, 1'b0, a, r);
            if (a) nacc++;
        end
        chk("throughput_accepts", 32'(nacc), 32'd8);
        for (int i = 0; i < 4; i++) step(1'b0, idle, 1'b1, 1'b0, a, r);
        chk("throughput_drained", 32'(q.size()), 32'd0);

        // Random valid/ready traffic
        idx = 0;
        for (int c = 0; c < 600 && !(idx == 30 && q.size() == 0); c++) begin
            if (idx < 30)
                step($urandom_range(3, 0) != 0, model(32'h0000_8000 + 32'(idx * 4), $urandom()),
                     $urandom_range(4, 0) > 1, 1'b0, a, r);
            else
                step(1'b0, idle, 1'b1, 1'b0, a, r);
            if (a) idx++;
        end
        chk("random_all_accepted", 32'(idx), 32'd30);
        chk("random_all_emitted", 32'(q.size()), 32'd0);

        // Long idle stretch saturates the bubble counter
        for (int i = 0; i < 300; i++) step(1'b0, idle, 1'b1, 1'b0, a, r);
        #1;
        chk("bubble_saturated", 32'(bubble_cnt), 32'd255);

        // Reset while words are held: nothing may emerge afterwards
        step(1'b1, model(32'h0000_9000, 32'h012A4020), 1'b0, 1'b0, a, r);
        step(1'b1, model(32'h0000_9004, 32'h00084880), 1'b0, 1'b0, a, r);
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, idle, 1'b1, 1'b0, a, r);
        step(1'b1, tv[1], 1'b1, 1'b0, a, r);
        step(1'b0, idle, 1'b1, 1'b0, a, r);
        chk("post_reset_drained", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
